// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns a stream of UART bytes into address/data commands.
// A frame is SYNC_BYTE, ADDR, DATA, CHK, where CHK = ADDR + DATA (mod 256).
// A good frame is presented on CMD_* until the consumer takes it.
// Breaks, checksum errors, inter-byte timeouts and overruns raise a one-cycle
// ERR_O strobe. ERR_CODE_O holds the cause of the most recent error.
//
// Ports:
//   CLK_I        system clock
//   RST_I        synchronous reset, active-high
//   RX_VLD_I     one-cycle strobe, received byte valid
//   RX_D_I[7:0]  received byte
//   RX_BREAK_I   break indication, qualified by RX_VLD_I
//   CMD_RDY_I    consumer ready
//   CMD_VLD_O    command available
//   CMD_ADDR_O   command address
//   CMD_DATA_O   command data
//   ERR_O        one-cycle error strobe
//   ERR_CODE_O   00 break, 01 checksum, 10 timeout, 11 overrun (sticky)
//   FRAME_CNT_O  good frames delivered, wrapping
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 81_000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        RX_VLD_I,
    input  logic [7:0]  RX_D_I,
    input  logic        RX_BREAK_I,
    input  logic        CMD_RDY_I,
    output logic        CMD_VLD_O,
    output logic [7:0]  CMD_ADDR_O,
    output logic [7:0]  CMD_DATA_O,
    output logic        ERR_O,
    output logic [1:0]  ERR_CODE_O,
    output logic [15:0] FRAME_CNT_O
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_BREAK   = 2'b00;
    localparam logic [1:0] ERR_CHKSUM  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_addr;
    logic [7:0]       r_data;
    logic             r_cmd_vld;
    logic [7:0]       r_cmd_addr;
    logic [7:0]       r_cmd_data;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [15:0]      r_frame_cnt;

    logic [7:0]       w_sum;
    logic             w_good;

    assign w_sum  = r_addr + r_data;
    assign w_good = (r_state == GET_CHK) && RX_VLD_I && !RX_BREAK_I && (RX_D_I == w_sum);

    // Frame FSM, timeout counter and output command register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_cmd_vld   <= 1'b0;
            r_cmd_addr  <= 8'h00;
            r_cmd_data  <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= ERR_BREAK;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_err <= 1'b0;

            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (RX_VLD_I && !RX_BREAK_I && (RX_D_I == SYNC_BYTE)) begin
                    r_state <= GET_ADDR;
                end
            end else if (RX_VLD_I) begin
                // A byte arriving on the expiry cycle takes precedence over the timeout.
                r_cnt <= '0;
                if (RX_BREAK_I) begin
                    r_state    <= IDLE;
                    r_err      <= 1'b1;
                    r_err_code <= ERR_BREAK;
                end else begin
                    case (r_state)
                        GET_ADDR: begin
                            r_addr  <= RX_D_I;
                            r_state <= GET_DATA;
                        end
                        GET_DATA: begin
                            r_data  <= RX_D_I;
                            r_state <= GET_CHK;
                        end
                        GET_CHK: begin
                            r_state <= IDLE;
                            if (RX_D_I != w_sum) begin
                                r_err      <= 1'b1;
                                r_err_code <= ERR_CHKSUM;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end else if (r_cnt == CNT_LAST) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // A good frame loads if the slot is free or is being emptied at this edge.
            if (w_good) begin
                if (!r_cmd_vld || CMD_RDY_I) begin
                    r_cmd_vld   <= 1'b1;
                    r_cmd_addr  <= r_addr;
                    r_cmd_data  <= r_data;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_OVERRUN;
                end
            end else if (r_cmd_vld && CMD_RDY_I) begin
                r_cmd_vld <= 1'b0;
            end
        end
    end

    assign CMD_VLD_O   = r_cmd_vld;
    assign CMD_ADDR_O  = r_cmd_addr;
    assign CMD_DATA_O  = r_cmd_data;
    assign ERR_O       = r_err;
    assign ERR_CODE_O  = r_err_code;
    assign FRAME_CNT_O = r_frame_cnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short timeout.
module tb_uart_cmd_parser;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_vld;
    logic [7:0]  rx_d;
    logic        rx_brk;
    logic        cmd_rdy;
    logic        cmd_vld;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .RX_VLD_I    (rx_vld),
        .RX_D_I      (rx_d),
        .RX_BREAK_I  (rx_brk),
        .CMD_RDY_I   (cmd_rdy),
        .CMD_VLD_O   (cmd_vld),
        .CMD_ADDR_O  (cmd_addr),
        .CMD_DATA_O  (cmd_data),
        .ERR_O       (err),
        .ERR_CODE_O  (err_code),
        .FRAME_CNT_O (frame_cnt)
    );

    always #5 clk = ~clk;

    // Count error strobes; the register is sampled at the edge after it is set.
    always @(posedge clk) begin
        if (!rst && err) err_seen <= err_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; the byte is sampled at the next posedge, and the
    // task returns at the following negedge with results visible.
    task automatic send_byte(input logic [7:0] d, input logic brk);
        rx_vld = 1'b1;
        rx_d   = d;
        rx_brk = brk;
        @(negedge clk);
        rx_vld = 1'b0;
        rx_d   = 8'h00;
        rx_brk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b0);
        send_byte(a, 1'b0);
        send_byte(d, 1'b0);
        send_byte(c, 1'b0);
    endtask

    task automatic consume(input string tag);
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        check(tag, 32'(cmd_vld), 32'd0);
    endtask

    initial begin
        int e0;
        rst = 1'b1; rx_vld = 1'b0; rx_d = 8'h00; rx_brk = 1'b0; cmd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_vld",  32'(cmd_vld),   32'd0);
        check("rst_addr", 32'(cmd_addr),  32'd0);
        check("rst_data", 32'(cmd_data),  32'd0);
        check("rst_err",  32'(err),       32'd0);
        check("rst_code", 32'(err_code),  32'd0);
        check("rst_cnt",  32'(frame_cnt), 32'd0);

        // Basic good frame, consumer not ready.
        send_frame(8'h12, 8'h34, 8'h46);
        check("good_vld",  32'(cmd_vld),   32'd1);
        check("good_addr", 32'(cmd_addr),  32'h12);
        check("good_data", 32'(cmd_data),  32'h34);
        check("good_cnt",  32'(frame_cnt), 32'd1);
        repeat (3) @(negedge clk);
        check("hold_vld",  32'(cmd_vld),   32'd1);
        check("hold_addr", 32'(cmd_addr),  32'h12);
        check("good_noerr", 32'(err_seen), 32'd0);
        consume("good_consume");

        // Checksum mismatch.
        send_frame(8'h12, 8'h34, 8'h47);
        check("chk_err",  32'(err),      32'd1);
        check("chk_code", 32'(err_code), 32'd1);
        check("chk_vld",  32'(cmd_vld),  32'd0);
        check("chk_cnt",  32'(frame_cnt), 32'd1);

        // Break in IDLE is ignored and leaves the sticky code alone.
        send_byte(8'h00, 1'b1);
        check("idlebrk_err",  32'(err),      32'd0);
        check("idlebrk_code", 32'(err_code), 32'd1);

        // Checksum wraps modulo 256.
        send_frame(8'hFF, 8'h02, 8'h01);
        check("wrap_vld",  32'(cmd_vld),   32'd1);
        check("wrap_addr", 32'(cmd_addr),  32'hFF);
        check("wrap_data", 32'(cmd_data),  32'h02);
        check("wrap_cnt",  32'(frame_cnt), 32'd2);
        consume("wrap_consume");

        // Timeout after TO silent clocks.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TO - 1) @(negedge clk);
        check("to_early", 32'(err), 32'd0);
        @(negedge clk);
        check("to_err",  32'(err),      32'd1);
        check("to_code", 32'(err_code), 32'd2);
        @(negedge clk);
        check("to_pulse", 32'(err), 32'd0);
        // FSM back in IDLE: a fresh frame decodes.
        send_frame(8'h03, 8'h04, 8'h07);
        check("to_idle_vld",  32'(cmd_vld),  32'd1);
        check("to_idle_addr", 32'(cmd_addr), 32'h03);
        consume("to_idle_consume");

        // Byte on the expiry cycle wins.
        e0 = err_seen;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h34, 1'b0);
        send_byte(8'h46, 1'b0);
        @(negedge clk);
        check("exp_noerr", 32'(err_seen - e0), 32'd0);
        check("exp_vld",   32'(cmd_vld),   32'd1);
        check("exp_data",  32'(cmd_data),  32'h34);
        check("exp_cnt",   32'(frame_cnt), 32'd4);
        consume("exp_consume");

        // Break mid-frame, carrying a byte that would be valid payload.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h00, 1'b1);
        check("brk_err",  32'(err),      32'd1);
        check("brk_code", 32'(err_code), 32'd0);
        check("brk_vld",  32'(cmd_vld),  32'd0);

        // Sync byte inside a frame is payload.
        send_frame(8'hA5, 8'h01, 8'hA6);
        check("syncpay_addr", 32'(cmd_addr),  32'hA5);
        check("syncpay_cnt",  32'(frame_cnt), 32'd5);
        consume("syncpay_consume");

        // Overrun: second frame dropped while first is pending.
        send_frame(8'h01, 8'h02, 8'h03);
        send_frame(8'h05, 8'h06, 8'h0B);
        check("ovr_err",  32'(err),       32'd1);
        check("ovr_code", 32'(err_code),  32'd3);
        check("ovr_addr", 32'(cmd_addr),  32'h01);
        check("ovr_data", 32'(cmd_data),  32'h02);
        check("ovr_cnt",  32'(frame_cnt), 32'd6);

        // Ready on the load edge: back-to-back load with no error.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        cmd_rdy = 1'b1;
        send_byte(8'h0F, 1'b0);
        cmd_rdy = 1'b0;
        check("b2b_err",  32'(err),       32'd0);
        check("b2b_vld",  32'(cmd_vld),   32'd1);
        check("b2b_addr", 32'(cmd_addr),  32'h07);
        check("b2b_data", 32'(cmd_data),  32'h08);
        check("b2b_cnt",  32'(frame_cnt), 32'd7);

        // Reset mid-frame with a command pending.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_vld",  32'(cmd_vld),   32'd0);
        check("mrst_addr", 32'(cmd_addr),  32'd0);
        check("mrst_data", 32'(cmd_data),  32'd0);
        check("mrst_err",  32'(err),       32'd0);
        check("mrst_code", 32'(err_code),  32'd0);
        check("mrst_cnt",  32'(frame_cnt), 32'd0);
        send_frame(8'h01, 8'h01, 8'h02);
        check("post_vld",  32'(cmd_vld),   32'd1);
        check("post_addr", 32'(cmd_addr),  32'h01);
        check("post_data", 32'(cmd_data),  32'h01);
        check("post_cnt",  32'(frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
